// File: rtl/lc3_execute_pkg.sv
// Shared types and constants for the LC-3 execute stage.
package lc3_execute_pkg;

  // ALU operation carried in E_control[5:4]
  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_t;

  // Address-offset select carried in E_control[3:2]
  typedef enum logic [1:0] {
    PCSEL_OFF11 = 2'b00,
    PCSEL_OFF9  = 2'b01,
    PCSEL_OFF6  = 2'b10,
    PCSEL_ZERO  = 2'b11
  } pcsel1_t;

  // Opcodes (IR[15:12]) the execute stage decodes
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  // E_control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int EC_ALU_HI    = 5;
  localparam int EC_ALU_LO    = 4;
  localparam int EC_PCSEL1_HI = 3;
  localparam int EC_PCSEL1_LO = 2;
  localparam int EC_PCSEL2    = 1;
  localparam int EC_OP2SEL    = 0;

endpackage

// File: rtl/lc3_execute_alu.sv
// Combinational ALU and address adder for the LC-3 execute stage.
module lc3_execute_alu
  import lc3_execute_pkg::*;
(
  input  alu_op_t     alu_op,
  input  pcsel1_t     pcsel1,
  input  logic        pcselect2,
  input  logic        op2select,
  input  logic [10:0] ir_low,
  input  logic [15:0] npc,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic [15:0] alu_result,
  output logic [15:0] pc_result
);

  logic [15:0] alu_b;
  logic [15:0] offset;
  logic [15:0] base;

  // Second ALU input: register operand or the 5-bit immediate
  always_comb begin
    alu_b = op2select ? op2 : {{11{ir_low[4]}}, ir_low[4:0]};
  end

  // ALU function; ADD wraps modulo 2^16, reserved encoding yields 0
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      ALU_ADD:  alu_result = op1 + alu_b;
      ALU_AND:  alu_result = op1 & alu_b;
      ALU_NOT:  alu_result = ~op1;
      default:  alu_result = 16'h0000;
    endcase
  end

  // Address offset selection and base+offset target
  always_comb begin
    offset = 16'h0000;
    case (pcsel1)
      PCSEL_OFF11: offset = {{5{ir_low[10]}}, ir_low[10:0]};
      PCSEL_OFF9:  offset = {{7{ir_low[8]}}, ir_low[8:0]};
      PCSEL_OFF6:  offset = {{10{ir_low[5]}}, ir_low[5:0]};
      default:     offset = 16'h0000;
    endcase
    base      = pcselect2 ? npc : op1;
    pc_result = base + offset;
  end

endmodule

// File: rtl/lc3_execute.sv
// LC-3 execute stage: register-address decode, operand bypass muxes,
// ALU/address computation and one registered pipeline stage.
// Handshake: there is no valid/ready pair; enable_execute=1 at a rising
// edge advances the stage, enable_execute=0 holds every output register.
module lc3_execute
  import lc3_execute_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_control,
  input  logic [1:0]  W_control,
  input  logic        Mem_control,
  input  logic [15:0] IR,
  input  logic [15:0] npc_out,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [1:0]  W_control_out,
  output logic        Mem_control_out,
  output logic [2:0]  dr,
  output logic [15:0] IR_exec,
  output logic [2:0]  NZP,
  output logic [15:0] M_data
);

  logic [3:0]  opcode;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] alu_result;
  logic [15:0] pc_result;
  logic [2:0]  nzp_next;
  alu_op_t     alu_op;
  pcsel1_t     pcsel1;

  assign opcode = IR[15:12];
  assign alu_op = alu_op_t'(E_control[EC_ALU_HI:EC_ALU_LO]);
  assign pcsel1 = pcsel1_t'(E_control[EC_PCSEL1_HI:EC_PCSEL1_LO]);

  // Register-file read addresses; stores read their data register as sr2
  always_comb begin
    sr1 = IR[8:6];
    sr2 = 3'b000;
    case (opcode)
      OP_ADD, OP_AND:        sr2 = IR[2:0];
      OP_ST, OP_STR, OP_STI: sr2 = IR[11:9];
      default:               sr2 = 3'b000;
    endcase
  end

  // Operand bypass: the registered ALU result outranks the memory value
  always_comb begin
    op1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    op2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
  end

  // Branch mask only for BR; JMP and everything else carry no condition
  always_comb begin
    nzp_next = (opcode == OP_BR) ? IR[11:9] : 3'b000;
  end

  lc3_execute_alu u_alu (
    .alu_op     (alu_op),
    .pcsel1     (pcsel1),
    .pcselect2  (E_control[EC_PCSEL2]),
    .op2select  (E_control[EC_OP2SEL]),
    .ir_low     (IR[10:0]),
    .npc        (npc_out),
    .op1        (op1),
    .op2        (op2),
    .alu_result (alu_result),
    .pc_result  (pc_result)
  );

  // Output pipeline register; reset wins over enable and clears everything
  always_ff @(posedge clock) begin
    if (reset) begin
      aluout          <= 16'h0000;
      pcout           <= 16'h0000;
      W_control_out   <= 2'b00;
      Mem_control_out <= 1'b0;
      dr              <= 3'b000;
      IR_exec         <= 16'h0000;
      NZP             <= 3'b000;
      M_data          <= 16'h0000;
    end else if (enable_execute) begin
      aluout          <= alu_result;
      pcout           <= pc_result;
      W_control_out   <= W_control;
      Mem_control_out <= Mem_control;
      dr              <= IR[11:9];
      IR_exec         <= IR;
      NZP             <= nzp_next;
      M_data          <= op2;
    end
  end

endmodule

// File: tb/tb_lc3_execute.sv
// Directed self-checking bench for the LC-3 execute stage.
module tb_lc3_execute;

  logic        clock;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        Mem_control;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [15:0] Mem_Bypass_Val;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [1:0]  W_control_out;
  logic        Mem_control_out;
  logic [2:0]  dr;
  logic [15:0] IR_exec;
  logic [2:0]  NZP;
  logic [15:0] M_data;

  int n_checks = 0;
  int n_pass   = 0;

  lc3_execute dut (
    .clock           (clock),
    .reset           (reset),
    .enable_execute  (enable_execute),
    .E_control       (E_control),
    .W_control       (W_control),
    .Mem_control     (Mem_control),
    .IR              (IR),
    .npc_out         (npc_out),
    .VSR1            (VSR1),
    .VSR2            (VSR2),
    .bypass_alu_1    (bypass_alu_1),
    .bypass_alu_2    (bypass_alu_2),
    .bypass_mem_1    (bypass_mem_1),
    .bypass_mem_2    (bypass_mem_2),
    .Mem_Bypass_Val  (Mem_Bypass_Val),
    .sr1             (sr1),
    .sr2             (sr2),
    .aluout          (aluout),
    .pcout           (pcout),
    .W_control_out   (W_control_out),
    .Mem_control_out (Mem_control_out),
    .dr              (dr),
    .IR_exec         (IR_exec),
    .NZP             (NZP),
    .M_data          (M_data)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One active edge, then settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one instruction with bypasses off and forwarded controls cleared
  task automatic drive(input logic [15:0] ir, input logic [5:0] ec,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [15:0] npc);
    IR             = ir;
    E_control      = ec;
    VSR1           = v1;
    VSR2           = v2;
    npc_out        = npc;
    W_control      = 2'b00;
    Mem_control    = 1'b0;
    bypass_alu_1   = 1'b0;
    bypass_alu_2   = 1'b0;
    bypass_mem_1   = 1'b0;
    bypass_mem_2   = 1'b0;
    Mem_Bypass_Val = 16'h0000;
    enable_execute = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    enable_execute = 1'($urandom_range(0, 1));
    IR             = 16'($urandom);
    E_control      = 6'($urandom);
    W_control      = 2'($urandom);
    Mem_control    = 1'($urandom);
    npc_out        = 16'($urandom);
    VSR1           = 16'($urandom);
    VSR2           = 16'($urandom);
    bypass_alu_1   = 1'($urandom);
    bypass_alu_2   = 1'($urandom);
    bypass_mem_1   = 1'($urandom);
    bypass_mem_2   = 1'($urandom);
    Mem_Bypass_Val = 16'($urandom);
    tick();
    enable_execute = 1'b1;
    IR             = 16'($urandom);
    VSR1           = 16'($urandom);
    tick();
    n_checks++; if (aluout !== 16'h0) $display("FAIL reset_aluout: got %h expected 0000", aluout); else n_pass++;
    n_checks++; if (pcout !== 16'h0) $display("FAIL reset_pcout: got %h expected 0000", pcout); else n_pass++;
    n_checks++; if (W_control_out !== 2'b0) $display("FAIL reset_wctl: got %b expected 00", W_control_out); else n_pass++;
    n_checks++; if (Mem_control_out !== 1'b0) $display("FAIL reset_memctl: got %b expected 0", Mem_control_out); else n_pass++;
    n_checks++; if (dr !== 3'b0) $display("FAIL reset_dr: got %h expected 0", dr); else n_pass++;
    n_checks++; if (IR_exec !== 16'h0) $display("FAIL reset_ir_exec: got %h expected 0000", IR_exec); else n_pass++;
    n_checks++; if (NZP !== 3'b0) $display("FAIL reset_nzp: got %b expected 000", NZP); else n_pass++;
    n_checks++; if (M_data !== 16'h0) $display("FAIL reset_mdata: got %h expected 0000", M_data); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_add_imm();
    // ADD R1,R1,#1: 0x7FFF+1 wraps into the sign bit
    drive(16'h1261, 6'b000000, 16'h7FFF, 16'h5555, 16'h3000);
    W_control   = 2'b01;
    Mem_control = 1'b1;
    #1;
    n_checks++; if (sr1 !== 3'd1) $display("FAIL add_sr1: got %0d expected 1", sr1); else n_pass++;
    n_checks++; if (sr2 !== 3'd1) $display("FAIL add_sr2: got %0d expected 1", sr2); else n_pass++;
    tick();
    n_checks++; if (aluout !== 16'h8000) $display("FAIL add_aluout: got %h expected 8000", aluout); else n_pass++;
    n_checks++; if (dr !== 3'd1) $display("FAIL add_dr: got %0d expected 1", dr); else n_pass++;
    n_checks++; if (NZP !== 3'b000) $display("FAIL add_nzp: got %b expected 000", NZP); else n_pass++;
    n_checks++; if (IR_exec !== 16'h1261) $display("FAIL add_ir_exec: got %h expected 1261", IR_exec); else n_pass++;
    // offset11 = sext(0x261) = 0x0261, base op1 = 0x7FFF
    n_checks++; if (pcout !== 16'h8260) $display("FAIL add_pcout: got %h expected 8260", pcout); else n_pass++;
    n_checks++; if (M_data !== 16'h5555) $display("FAIL add_mdata: got %h expected 5555", M_data); else n_pass++;
    n_checks++; if (W_control_out !== 2'b01) $display("FAIL add_wctl: got %b expected 01", W_control_out); else n_pass++;
    n_checks++; if (Mem_control_out !== 1'b1) $display("FAIL add_memctl: got %b expected 1", Mem_control_out); else n_pass++;
  endtask

  task automatic test_and_not();
    // AND R0,R1,R2
    drive(16'h5042, 6'b010001, 16'hF0F0, 16'h0FF0, 16'h0000);
    #1;
    n_checks++; if (sr2 !== 3'd2) $display("FAIL and_sr2: got %0d expected 2", sr2); else n_pass++;
    tick();
    n_checks++; if (aluout !== 16'h00F0) $display("FAIL and_aluout: got %h expected 00f0", aluout); else n_pass++;
    // ADD R0,R1,R2 register form with wrap
    drive(16'h1042, 6'b000001, 16'hFFFF, 16'h0002, 16'h0000);
    tick();
    n_checks++; if (aluout !== 16'h0001) $display("FAIL add_wrap_aluout: got %h expected 0001", aluout); else n_pass++;
    // NOT R1,R1 with offset6 = sext(0x3F) = -1
    drive(16'h927F, 6'b101000, 16'h00FF, 16'h1111, 16'h0000);
    tick();
    n_checks++; if (aluout !== 16'hFF00) $display("FAIL not_aluout: got %h expected ff00", aluout); else n_pass++;
    n_checks++; if (pcout !== 16'h00FE) $display("FAIL off6_pcout: got %h expected 00fe", pcout); else n_pass++;
    // Reserved ALU op, zero offset
    drive(16'h1261, 6'b111100, 16'h4321, 16'h1111, 16'h0000);
    tick();
    n_checks++; if (aluout !== 16'h0000) $display("FAIL rsvd_aluout: got %h expected 0000", aluout); else n_pass++;
    n_checks++; if (pcout !== 16'h4321) $display("FAIL zero_off_pcout: got %h expected 4321", pcout); else n_pass++;
  endtask

  task automatic test_branch();
    // BRnp #5 from npc 0x3001
    drive(16'h0A05, 6'b000110, 16'h1111, 16'h2222, 16'h3001);
    tick();
    n_checks++; if (pcout !== 16'h3006) $display("FAIL br_pcout: got %h expected 3006", pcout); else n_pass++;
    n_checks++; if (NZP !== 3'b101) $display("FAIL br_nzp: got %b expected 101", NZP); else n_pass++;
    // JMP R7: target is the register, no mask
    drive(16'hC1C0, 6'b001100, 16'h4000, 16'h2222, 16'h3001);
    #1;
    n_checks++; if (sr1 !== 3'd7) $display("FAIL jmp_sr1: got %0d expected 7", sr1); else n_pass++;
    n_checks++; if (sr2 !== 3'd0) $display("FAIL jmp_sr2: got %0d expected 0", sr2); else n_pass++;
    tick();
    n_checks++; if (pcout !== 16'h4000) $display("FAIL jmp_pcout: got %h expected 4000", pcout); else n_pass++;
    n_checks++; if (NZP !== 3'b000) $display("FAIL jmp_nzp: got %b expected 000", NZP); else n_pass++;
    // BRnzp with offset11 = sext(0x7FF) = -1 from npc 0x3001
    drive(16'h0FFF, 6'b000010, 16'h1111, 16'h2222, 16'h3001);
    tick();
    n_checks++; if (pcout !== 16'h3000) $display("FAIL br11_pcout: got %h expected 3000", pcout); else n_pass++;
    n_checks++; if (NZP !== 3'b111) $display("FAIL br11_nzp: got %b expected 111", NZP); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    // Registers hold the BRnzp result; reset with enable low must still clear
    IR             = 16'h1261;
    VSR1           = 16'h0AAA;
    enable_execute = 1'b0;
    reset          = 1'b1;
    tick();
    n_checks++; if (pcout !== 16'h0) $display("FAIL midreset_pcout: got %h expected 0000", pcout); else n_pass++;
    n_checks++; if (NZP !== 3'b0) $display("FAIL midreset_nzp: got %b expected 000", NZP); else n_pass++;
    n_checks++; if (IR_exec !== 16'h0) $display("FAIL midreset_ir_exec: got %h expected 0000", IR_exec); else n_pass++;
    reset = 1'b0;
    drive(16'h1261, 6'b000000, 16'h0005, 16'h0000, 16'h0000);
    tick();
    n_checks++; if (aluout !== 16'h0006) $display("FAIL after_reset_aluout: got %h expected 0006", aluout); else n_pass++;
  endtask

  task automatic test_bypass();
    drive(16'h1261, 6'b000000, 16'h1233, 16'h0000, 16'h0000);
    tick();
    // ADD R1,R1,#0 with both op1 bypasses: ALU result wins
    drive(16'h1260, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
    bypass_alu_1   = 1'b1;
    bypass_mem_1   = 1'b1;
    Mem_Bypass_Val = 16'hBEEF;
    tick();
    n_checks++; if (aluout !== 16'h1234) $display("FAIL bypass_prio_aluout: got %h expected 1234", aluout); else n_pass++;
    bypass_alu_1 = 1'b0;
    tick();
    n_checks++; if (aluout !== 16'hBEEF) $display("FAIL bypass_mem1_aluout: got %h expected beef", aluout); else n_pass++;
    // AND with op2 from the ALU result
    drive(16'h5042, 6'b010001, 16'hFFFF, 16'h0000, 16'h0000);
    bypass_alu_2 = 1'b1;
    tick();
    n_checks++; if (aluout !== 16'hBEEF) $display("FAIL bypass_alu2_aluout: got %h expected beef", aluout); else n_pass++;
    n_checks++; if (M_data !== 16'hBEEF) $display("FAIL bypass_alu2_mdata: got %h expected beef", M_data); else n_pass++;
    // AND with op2 from memory
    drive(16'h5042, 6'b010001, 16'hFFFF, 16'h0000, 16'h0000);
    bypass_mem_2   = 1'b1;
    Mem_Bypass_Val = 16'h00FF;
    VSR1           = 16'hBEEF;
    tick();
    n_checks++; if (aluout !== 16'h00EF) $display("FAIL bypass_mem2_aluout: got %h expected 00ef", aluout); else n_pass++;
    n_checks++; if (M_data !== 16'h00FF) $display("FAIL bypass_mem2_mdata: got %h expected 00ff", M_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_val;
    drive(16'h1261, 6'b000000, 16'h0010, 16'h0000, 16'h0000);
    tick();
    n_checks++; if (aluout !== 16'h0011) $display("FAIL chain_seed: got %h expected 0011", aluout); else n_pass++;
    bypass_alu_1 = 1'b1;
    VSR1         = 16'h9999;
    exp_val      = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      exp_val = exp_val + 16'h0001;
      tick();
      n_checks++; if (aluout !== exp_val) $display("FAIL chain_%0d: got %h expected %h", i, aluout, exp_val); else n_pass++;
    end
  endtask

  task automatic test_stall_store();
    drive(16'h1261, 6'b000000, 16'h0100, 16'h7777, 16'h0000);
    tick();
    enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IR        = 16'($urandom);
      E_control = 6'($urandom);
      VSR1      = 16'($urandom);
      VSR2      = 16'($urandom);
      W_control = 2'b11;
      tick();
      n_checks++; if (aluout !== 16'h0101) $display("FAIL stall_aluout_%0d: got %h expected 0101", i, aluout); else n_pass++;
      n_checks++; if (pcout !== 16'h0361) $display("FAIL stall_pcout_%0d: got %h expected 0361", i, pcout); else n_pass++;
      n_checks++; if (IR_exec !== 16'h1261) $display("FAIL stall_ir_exec_%0d: got %h expected 1261", i, IR_exec); else n_pass++;
      n_checks++; if (M_data !== 16'h7777) $display("FAIL stall_mdata_%0d: got %h expected 7777", i, M_data); else n_pass++;
      n_checks++; if (W_control_out !== 2'b00) $display("FAIL stall_wctl_%0d: got %b expected 00", i, W_control_out); else n_pass++;
    end
    // Bypass after the stall sees the held result
    drive(16'h1261, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
    bypass_alu_1 = 1'b1;
    tick();
    n_checks++; if (aluout !== 16'h0102) $display("FAIL stall_bypass_aluout: got %h expected 0102", aluout); else n_pass++;
    // STR R3,R1,#2
    drive(16'h7642, 6'b001000, 16'h4000, 16'hCAFE, 16'h0000);
    #1;
    n_checks++; if (sr2 !== 3'd3) $display("FAIL str_sr2: got %0d expected 3", sr2); else n_pass++;
    tick();
    n_checks++; if (M_data !== 16'hCAFE) $display("FAIL str_mdata: got %h expected cafe", M_data); else n_pass++;
    n_checks++; if (pcout !== 16'h4002) $display("FAIL str_pcout: got %h expected 4002", pcout); else n_pass++;
    n_checks++; if (dr !== 3'd3) $display("FAIL str_dr: got %0d expected 3", dr); else n_pass++;
    // ST, STI and a non-store opcode
    IR = 16'h3A05;
    #1;
    n_checks++; if (sr2 !== 3'd5) $display("FAIL st_sr2: got %0d expected 5", sr2); else n_pass++;
    IR = 16'hBC00;
    #1;
    n_checks++; if (sr2 !== 3'd6) $display("FAIL sti_sr2: got %0d expected 6", sr2); else n_pass++;
    IR = 16'h2A07;
    #1;
    n_checks++; if (sr2 !== 3'd0) $display("FAIL ld_sr2: got %0d expected 0", sr2); else n_pass++;
  endtask

  // Test sequence and final report
  initial begin
    reset = 1'b1;
    drive(16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_add_imm();
    test_and_not();
    test_branch();
    test_reset_midstream();
    test_bypass();
    test_back_to_back();
    test_stall_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_execute.md
# lc3_execute

Execute stage of the LC-3 pipeline, directly downstream of the decode stage. It consumes the decode_out bus (W_control, Mem_control, E_control, IR, npc_out) plus register-file read data. It computes the ALU result, the branch/memory address and the branch NZP mask, and forwards its controls to the writeback/memory-access stages through one registered pipeline stage. Operands can be bypassed from the previous execute result or from memory.

## Interface
- No parameters; all widths are fixed by the LC-3 ISA (16-bit datapath).
- clock  in  1  stage clock, rising edge
- reset  in  1  synchronous, active-high
- enable_execute  in  1  stage advance; when 0 all output registers hold
- E_control  in  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select} from decode
- W_control  in  2  writeback select, forwarded
- Mem_control  in  1  memory-access control, forwarded
- IR  in  16  instruction from decode
- npc_out  in  16  PC+1 of the instruction
- VSR1, VSR2  in  16 each  register-file read data for sr1/sr2
- bypass_alu_1, bypass_alu_2  in  1 each  replace operand 1/2 with the registered aluout
- bypass_mem_1, bypass_mem_2  in  1 each  replace operand 1/2 with Mem_Bypass_Val
- Mem_Bypass_Val  in  16  value from the memory stage
- sr1, sr2  out  3 each  combinational register-file read addresses
- aluout  out  16  registered ALU result
- pcout  out  16  registered address/target
- W_control_out  out  2  registered
- Mem_control_out  out  1  registered
- dr  out  3  registered destination, IR[11:9]
- IR_exec  out  16  registered IR
- NZP  out  3  registered branch condition mask
- M_data  out  16  registered store data (operand 2 after bypass)

## Operation
- Address decode, combinational from IR:
  - sr1 = IR[8:6].
  - sr2 = IR[2:0] for ALU ops (opcodes 0001, 0101).
  - sr2 = IR[11:9] for ST/STR/STI (0011, 0111, 1011).
  - sr2 = 0 for all other opcodes.
- Operand select:
  - op1 = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1. ALU bypass takes priority over memory bypass when both are asserted.
  - op2 is resolved the same way from bypass_alu_2, bypass_mem_2 and VSR2.
- ALU second input = op2select ? op2 : sext(IR[4:0]).
- alu_control:
  - 00 ADD (16-bit, wraps modulo 2^16, no carry out)
  - 01 AND
  - 10 NOT op1
  - 11 reserved, result 0
- pcselect1 offset:
  - 00 sext(IR[10:0])
  - 01 sext(IR[8:0])
  - 10 sext(IR[5:0])
  - 11 zero
- pcout = (pcselect2 ? npc_out : op1) + offset, mod 2^16.
- NZP:
  - IR[11:9] when IR[15:12] = 0000 (BR).
  - 000 for JMP (1100), which is an unconditional target with no mask.
  - 000 for every other opcode.
- All registered outputs load on a rising clock edge with enable_execute=1. They hold while enable_execute=0.
- No internal state beyond the output pipeline registers. aluout feeds back only through the bypass path.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on the registered outputs after edge N. sr1/sr2 have zero latency.
- reset=1 at an edge clears every registered output to 0 (aluout, pcout, W_control_out, Mem_control_out, dr, IR_exec, NZP, M_data). This happens regardless of enable_execute; reset wins.
- Reset mid-stream discards the in-flight instruction. The first instruction after reset deasserts is processed normally.
- Bypass with enable_execute=0: the registers do not change, so a bypass_alu request sees the held aluout.
- Back-to-back dependent ADDs with bypass_alu_1=1 chain every cycle with no stall.

## Structure
- Shared package lc3_execute_pkg holds:
  - typedef alu_op_t {ADD, AND, NOT, RSVD}
  - typedef pcsel1_t
  - opcode localparams (BR, ADD, AND, NOT, ST, STR, STI, JMP)
  - the E_control field positions
- Sub-module lc3_execute_alu: pure combinational ALU plus the pcout adder.
- Top level holds the operand muxes, NZP/sr decode and pipeline registers.

## Test plan
- Reset: drive reset=1 for 2 cycles with random inputs. Required: all registered outputs 0, then normal operation on the first cycle after reset deasserts.
- ADD immediate: IR=0x1261 (ADD R1,R1,#1), VSR1=0x7FFF, E_control=000000. Required: aluout=0x8000, dr=1, NZP=000, sr1=1.
- AND/NOT with wrap:
  - AND register, IR=0x5042, VSR1=0xF0F0, VSR2=0x0FF0, E_control=010001. Required: aluout=0x00F0.
  - ADD, VSR1=0xFFFF, VSR2=0x0002, E_control=000001. Required: aluout=0x0001.
- Branch: IR=0x0A05 (BRnp #5), npc_out=0x3001, E_control=000110. Required: pcout=0x3006, NZP=101.
- Bypass priority: bypass_alu_1=1, bypass_mem_1=1, previous aluout=0x1234, Mem_Bypass_Val=0xBEEF, ADD #0. Required: aluout=0x1234. With bypass_alu_1=0: aluout=0xBEEF.
- Stall and store: hold enable_execute=0 for 3 cycles while inputs change. Required: outputs unchanged. Then STR R3 with VSR2=0xCAFE. Required: M_data=0xCAFE, sr2=3.
